// File: rtl/delay_tap_detector.sv
// Delay tap detector: works out which of four reference-history taps (0..3
// cycles) lines up with an incoming delayed byte stream. It locks onto that
// tap after a run of matches and drops the lock after a run of misses, so a
// downstream tap mux can follow the sel output.
module delay_tap_detector #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_ref,
  input  logic [WIDTH-1:0] d_dly,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             ambiguous
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Counter ceilings in the 8-bit counter domain. The miss threshold is one
  // bit wider so that miss_cnt + 1 cannot overflow in the comparison.
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_COUNT);
  localparam logic [8:0] MISS_MAX = 9'(MISS_LIMIT);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] h1_r;
  logic [WIDTH-1:0] h2_r;
  logic [WIDTH-1:0] h3_r;
  logic [1:0]       fill_r;
  logic [1:0]       fill_s;
  logic [7:0]       cnt_r [4];
  logic [7:0]       cnt_s [4];
  logic [7:0]       miss_cnt_r;
  logic [7:0]       miss_cnt_s;
  logic [1:0]       sel_r;
  logic [1:0]       sel_s;
  logic             locked_r;
  logic             locked_s;
  logic             ambiguous_r;
  logic             ambiguous_s;

  logic [WIDTH-1:0] tap_s [4];
  logic [3:0]       match_s;
  logic [3:0]       sat_s;
  logic [2:0]       sat_num_s;
  logic             tap_hit_s;

  // Number of candidates that have reached the lock threshold.
  function automatic logic [2:0] count_ones(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Index of the single saturated candidate; only meaningful for one-hot input.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Tap k presents the reference delayed by k cycles; tap 0 is the live input.
  always_comb begin
    tap_s[0] = d_ref;
    tap_s[1] = h1_r;
    tap_s[2] = h2_r;
    tap_s[3] = h3_r;
  end

  // Per-candidate match (only once the history holds valid data for that tap)
  // and saturation flags, plus the comparison against the locked tap.
  always_comb begin
    match_s = 4'b0000;
    sat_s   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      match_s[k] = (d_dly == tap_s[k]) && (fill_r >= 2'(k));
      sat_s[k]   = (cnt_r[k] == LOCK_MAX);
    end
    sat_num_s = count_ones(sat_s);
    tap_hit_s = (d_dly == tap_s[sel_r]);
  end

  // Next-state and next-output logic for the SEARCH / LOCKED machine.
  always_comb begin
    state_s     = state_r;
    fill_s      = (fill_r == 2'd3) ? 2'd3 : fill_r + 2'd1;
    miss_cnt_s  = miss_cnt_r;
    sel_s       = sel_r;
    locked_s    = locked_r;
    ambiguous_s = ambiguous_r;
    for (int k = 0; k < 4; k++) begin
      cnt_s[k] = cnt_r[k];
    end

    case (state_r)
      SEARCH: begin
        for (int k = 0; k < 4; k++) begin
          if (match_s[k]) begin
            cnt_s[k] = (cnt_r[k] >= LOCK_MAX) ? LOCK_MAX : cnt_r[k] + 8'd1;
          end else begin
            cnt_s[k] = 8'd0;
          end
        end
        // Decision uses the counters as they stood before this edge.
        if (sat_num_s == 3'd1) begin
          state_s     = LOCKED;
          sel_s       = onehot_index(sat_s);
          locked_s    = 1'b1;
          ambiguous_s = 1'b0;
          miss_cnt_s  = 8'd0;
        end else if (sat_num_s >= 3'd2) begin
          ambiguous_s = 1'b1;
        end else begin
          ambiguous_s = 1'b0;
        end
      end
      LOCKED: begin
        ambiguous_s = 1'b0;
        if (tap_hit_s) begin
          miss_cnt_s = 8'd0;
        end else if (({1'b0, miss_cnt_r} + 9'd1) < MISS_MAX) begin
          miss_cnt_s = miss_cnt_r + 8'd1;
        end else begin
          // Too many misses: go back to searching, keep sel for the mux.
          state_s    = SEARCH;
          locked_s   = 1'b0;
          miss_cnt_s = 8'd0;
          for (int k = 0; k < 4; k++) begin
            cnt_s[k] = 8'd0;
          end
        end
      end
      default: begin
        state_s     = SEARCH;
        locked_s    = 1'b0;
        ambiguous_s = 1'b0;
        miss_cnt_s  = 8'd0;
        for (int k = 0; k < 4; k++) begin
          cnt_s[k] = 8'd0;
        end
      end
    endcase
  end

  // State, history, counters and outputs; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SEARCH;
      h1_r        <= '0;
      h2_r        <= '0;
      h3_r        <= '0;
      fill_r      <= 2'd0;
      miss_cnt_r  <= 8'd0;
      sel_r       <= 2'd0;
      locked_r    <= 1'b0;
      ambiguous_r <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= 8'd0;
      end
    end else begin
      state_r     <= state_s;
      h1_r        <= d_ref;
      h2_r        <= h1_r;
      h3_r        <= h2_r;
      fill_r      <= fill_s;
      miss_cnt_r  <= miss_cnt_s;
      sel_r       <= sel_s;
      locked_r    <= locked_s;
      ambiguous_r <= ambiguous_s;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= cnt_s[k];
      end
    end
  end

  assign sel       = sel_r;
  assign locked    = locked_r;
  assign ambiguous = ambiguous_r;

endmodule

// File: tb/tb_delay_tap_detector.sv
// Testbench for delay_tap_detector: a table of directed vectors for the
// basic lock cases, then hand-written sequences for ambiguity, miss handling,
// reset while locked, and a LOCK_COUNT=1 / MISS_LIMIT=1 build.
module tb_delay_tap_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_ref;
  logic [7:0] d_dly;
  logic [1:0] sel;
  logic       locked;
  logic       ambiguous;

  logic       reset1;
  logic [7:0] d_ref1;
  logic [7:0] d_dly1;
  logic [1:0] sel1;
  logic       locked1;
  logic       ambiguous1;

  int checks = 0;
  int passes = 0;

  // Reference values applied on past edges (index k = k edges ago), modelling
  // an upstream delay line that is not affected by the detector's reset.
  logic [7:0] hist [4];

  typedef struct {
    logic       rst_in;
    logic [7:0] ref_in;
    logic [7:0] dly_in;
    logic [1:0] sel_exp;
    logic       locked_exp;
    logic       amb_exp;
  } vec_t;

  vec_t tbl [0:31];
  int   n_vec;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  delay_tap_detector #(.WIDTH(8), .LOCK_COUNT(8), .MISS_LIMIT(2)) dut (
    .clk(clk), .reset(reset), .d_ref(d_ref), .d_dly(d_dly),
    .sel(sel), .locked(locked), .ambiguous(ambiguous)
  );

  delay_tap_detector #(.WIDTH(8), .LOCK_COUNT(1), .MISS_LIMIT(1)) dut_fast (
    .clk(clk), .reset(reset1), .d_ref(d_ref1), .d_dly(d_dly1),
    .sel(sel1), .locked(locked1), .ambiguous(ambiguous1)
  );

  function automatic logic [7:0] dly(input int d, input logic [7:0] r);
    return (d == 0) ? r : hist[d];
  endfunction

  task automatic step(input logic rst, input logic [7:0] r, input logic [7:0] dl);
    reset = rst;
    d_ref = r;
    d_dly = dl;
    @(posedge clk);
    #1;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = r;
  endtask

  task automatic step_fast(input logic rst, input logic [7:0] r, input logic [7:0] dl);
    reset1 = rst;
    d_ref1 = r;
    d_dly1 = dl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkm(input string name, input logic [1:0] es, input logic el, input logic ea);
    checks++;
    if ({sel, locked, ambiguous} === {es, el, ea}) begin
      passes++;
    end else begin
      $display("FAIL %s: sel/locked/ambiguous got %0d/%b/%b required %0d/%b/%b",
               name, sel, locked, ambiguous, es, el, ea);
    end
  endtask

  task automatic checkf(input string name, input logic [1:0] es, input logic el, input logic ea);
    checks++;
    if ({sel1, locked1, ambiguous1} === {es, el, ea}) begin
      passes++;
    end else begin
      $display("FAIL %s: sel/locked/ambiguous got %0d/%b/%b required %0d/%b/%b",
               name, sel1, locked1, ambiguous1, es, el, ea);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       corrupt [4];
    logic       lk_exp [4];

    reset  = 1'b1;
    d_ref  = 8'h00;
    d_dly  = 8'h00;
    reset1 = 1'b1;
    d_ref1 = 8'h00;
    d_dly1 = 8'h00;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;

    // Table: reset, delay-2 counting data, reset, delay-0 data from 8'h10.
    n_vec = 0;
    tbl[n_vec] = '{1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
    n_vec++;
    // First delay-2 match is edge 3, counter hits 8 on edge 10, lock on edge 11.
    for (int k = 1; k <= 14; k++) begin
      tbl[n_vec] = '{1'b0, 8'(k), (k >= 3) ? 8'(k - 2) : 8'h00,
                     (k >= 11) ? 2'd2 : 2'd0, (k >= 11), 1'b0};
      n_vec++;
    end
    tbl[n_vec] = '{1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0};
    n_vec++;
    // Delay 0 matches from edge 1, counter hits 8 on edge 8, lock on edge 9.
    for (int k = 1; k <= 12; k++) begin
      tbl[n_vec] = '{1'b0, 8'h10 + 8'(k - 1), 8'h10 + 8'(k - 1),
                     2'd0, (k >= 9), 1'b0};
      n_vec++;
    end

    for (int i = 0; i < n_vec; i++) begin
      step(tbl[i].rst_in, tbl[i].ref_in, tbl[i].dly_in);
      checkm($sformatf("vec%0d", i), tbl[i].sel_exp, tbl[i].locked_exp, tbl[i].amb_exp);
    end

    // Ambiguity: prime the history with 8'hA5 while d_dly never matches, so
    // all four candidates start counting together and saturate on the same edge.
    step(1'b1, 8'h00, 8'h00);
    checkm("amb_reset", 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 8'hA5, 8'h5A);
      checkm($sformatf("amb_prime%0d", i), 2'd0, 1'b0, 1'b0);
    end
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 8'hA5, 8'hA5);
      checkm($sformatf("amb_const%0d", n), 2'd0, 1'b0, (n >= 9));
    end
    // Counting data at delay 3: taps 1..3 stay saturated on the trailing
    // 8'hA5 samples and fall away one by one until only tap 3 is left.
    for (int j = 1; j <= 6; j++) begin
      r = 8'(j);
      step(1'b0, r, dly(3, r));
      checkm($sformatf("amb_d3_%0d", j), (j >= 4) ? 2'd3 : 2'd0, (j >= 4), (j <= 3));
    end

    // Miss handling at delay 1, then re-acquire at delay 2.
    step(1'b1, 8'h00, 8'h00);
    checkm("miss_reset", 2'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      r = 8'h20 + 8'(e);
      step(1'b0, r, dly(1, r));
      checkm($sformatf("miss_acq%0d", e), (e >= 10) ? 2'd1 : 2'd0, (e >= 10), 1'b0);
    end
    corrupt[0] = 1'b1; corrupt[1] = 1'b0; corrupt[2] = 1'b1; corrupt[3] = 1'b1;
    lk_exp[0]  = 1'b1; lk_exp[1]  = 1'b1; lk_exp[2]  = 1'b1; lk_exp[3]  = 1'b0;
    for (int e = 13; e <= 16; e++) begin
      r = 8'h20 + 8'(e);
      step(1'b0, r, corrupt[e - 13] ? (dly(1, r) ^ 8'hFF) : dly(1, r));
      checkm($sformatf("miss_hit%0d", e), 2'd1, lk_exp[e - 13], 1'b0);
    end
    for (int e = 17; e <= 26; e++) begin
      r = 8'h20 + 8'(e);
      step(1'b0, r, dly(2, r));
      checkm($sformatf("miss_reacq%0d", e), (e >= 25) ? 2'd2 : 2'd1, (e >= 25), 1'b0);
    end

    // Reset while locked at sel=3; the delay-3 tap must wait for fill=3.
    step(1'b1, 8'h00, 8'h00);
    checkm("rst_reset", 2'd0, 1'b0, 1'b0);
    for (int e = 1; e <= 14; e++) begin
      r = 8'h40 + 8'(e);
      step(1'b0, r, dly(3, r));
      checkm($sformatf("rst_acq%0d", e), (e >= 12) ? 2'd3 : 2'd0, (e >= 12), 1'b0);
    end
    r = 8'h4F;
    step(1'b1, r, dly(3, r));
    checkm("rst_midlock", 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      r = 8'h4F + 8'(k);
      step(1'b0, r, dly(3, r));
      checkm($sformatf("rst_reacq%0d", k), (k >= 12) ? 2'd3 : 2'd0, (k >= 12), 1'b0);
    end

    // LOCK_COUNT=1, MISS_LIMIT=1 build.
    step_fast(1'b1, 8'h00, 8'h00);
    checkf("fast_reset", 2'd0, 1'b0, 1'b0);
    step_fast(1'b0, 8'h31, 8'h77);
    checkf("fast_e1", 2'd0, 1'b0, 1'b0);
    step_fast(1'b0, 8'h32, 8'h31);
    checkf("fast_e2", 2'd0, 1'b0, 1'b0);
    step_fast(1'b0, 8'h33, 8'h32);
    checkf("fast_lock", 2'd1, 1'b1, 1'b0);
    step_fast(1'b0, 8'h34, 8'h33);
    checkf("fast_hold", 2'd1, 1'b1, 1'b0);
    step_fast(1'b0, 8'h35, 8'h00);
    checkf("fast_drop", 2'd1, 1'b0, 1'b0);
    step_fast(1'b0, 8'h36, 8'h35);
    checkf("fast_rematch", 2'd1, 1'b0, 1'b0);
    step_fast(1'b0, 8'h37, 8'h36);
    checkf("fast_relock", 2'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
